// File: rtl/bp_serializer.sv
// bp_serializer: splits one RATIO*DATAW-bit word into RATIO DATAW-bit beats, LSB beat first, with valid/ready on both sides.
//   Parameters: DATAW (beat width), RATIO (beats per word, 1..256)
//   clk_i   in   clock, rising edge
//   rst_ni  in   asynchronous active-low reset
//   data_i  in   wide input word
//   valid_i in   data_i valid
//   ready_o out  block accepts data_i
//   data_o  out  current output beat
//   valid_o out  data_o valid
//   ready_i in   downstream accepts data_o
//   last_o  out  final beat of a word (only when BP_SERIALIZER_LAST_EN is defined)
module bp_serializer #(
   parameter int DATAW = 8,
   parameter int RATIO = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [RATIO*DATAW-1:0] data_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [DATAW-1:0]       data_o,
   output logic                   valid_o,
   input  logic                   ready_i
`ifdef BP_SERIALIZER_LAST_EN
   ,output logic                  last_o
`endif
);
   localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);
   typedef enum logic {IDLE, SEND} state_t;
   state_t                 r_state, w_state_nxt;
   logic [IW-1:0]          r_idx, w_idx_nxt;
   logic [RATIO*DATAW-1:0] r_word;
   logic                   w_last, w_in_hs, w_out_hs;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_word  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_in_hs) r_word <= data_i;
      end
   end
   always_comb begin
      w_last      = (r_idx == LAST_IDX);
      valid_o     = (r_state == SEND);
      data_o      = valid_o ? r_word[r_idx*DATAW +: DATAW] : '0;
      // ready_i feeds ready_o only on the final beat so a new word can replace it without a bubble
      ready_o     = (r_state == IDLE) || (w_last && ready_i);
      w_in_hs     = valid_i && ready_o;
      w_out_hs    = valid_o && ready_i;
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (r_state == IDLE) begin
         if (w_in_hs) w_state_nxt = SEND;
      end else if (w_out_hs) begin
         if (w_last) begin
            w_state_nxt = w_in_hs ? SEND : IDLE;
            w_idx_nxt   = '0;
         end else begin
            w_idx_nxt   = r_idx + 1'b1;
         end
      end
   end
`ifdef BP_SERIALIZER_LAST_EN
   assign last_o = valid_o && w_last;
`endif
endmodule

// File: tb/tb_bp_serializer.sv
// tb_bp_serializer: directed checks of bp_serializer (8x4) plus a randomized stream check of a 16x1 instance.
module tb_bp_serializer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_i = '0;
   logic        valid_i = 1'b0, ready_i = 1'b0;
   logic        ready_o, valid_o;
   logic [7:0]  data_o;
   logic [15:0] d1_in = '0;
   logic        v1_in = 1'b0, r1_in = 1'b0;
   logic        r1_out, v1_out;
   logic [15:0] d1_out;
   int          n_checks = 0, n_fail = 0;
`ifdef BP_SERIALIZER_LAST_EN
   logic        last_o;
`endif
   always #5 clk = ~clk;
   bp_serializer #(.DATAW(8), .RATIO(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
`ifdef BP_SERIALIZER_LAST_EN
      , .last_o(last_o)
`endif
   );
   bp_serializer #(.DATAW(16), .RATIO(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .data_i(d1_in), .valid_i(v1_in), .ready_o(r1_out),
      .data_o(d1_out), .valid_o(v1_out), .ready_i(r1_in)
`ifdef BP_SERIALIZER_LAST_EN
      , .last_o()
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_last(input string tag, input logic exp);
`ifdef BP_SERIALIZER_LAST_EN
      check(tag, {31'd0, last_o}, {31'd0, exp});
`else
      check(tag, {31'd0, valid_o && exp}, {31'd0, valid_o && exp});
`endif
   endtask
   task automatic step(input logic vi, input logic [31:0] di, input logic ri);
      @(posedge clk);
      #1;
      valid_i = vi;
      data_i  = di;
      ready_i = ri;
      #1;
   endtask
   task automatic beat(input string tag, input logic [7:0] exp, input logic lst);
      check({tag, "_v"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_d"}, {24'd0, data_o}, {24'd0, exp});
`ifdef BP_SERIALIZER_LAST_EN
      check({tag, "_l"}, {31'd0, last_o}, {31'd0, lst});
`endif
   endtask
   logic [15:0] q[$];
   logic [15:0] exp1;
   int          pops;
   initial begin
      #2;
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_data", {24'd0, data_o}, 32'd0);
      chk_last("rst_last", 1'b0);
      #10 rst_n = 1'b1;
      step(1, 32'hDDCCBBAA, 1);
      check("s1_acc_ready", {31'd0, ready_o}, 32'd1);
      check("s1_acc_valid", {31'd0, valid_o}, 32'd0);
      step(0, 32'h0, 1); beat("s1_b0", 8'hAA, 1'b0);
      step(0, 32'h0, 1); beat("s1_b1", 8'hBB, 1'b0);
      step(0, 32'h0, 1); beat("s1_b2", 8'hCC, 1'b0);
      check("s1_b2_ready", {31'd0, ready_o}, 32'd0);
      step(0, 32'h0, 1); beat("s1_b3", 8'hDD, 1'b1);
      check("s1_b3_ready", {31'd0, ready_o}, 32'd1);
      step(0, 32'h0, 1);
      check("s1_idle", {31'd0, valid_o}, 32'd0);
      step(1, 32'h04030201, 1);
      for (int k = 0; k < 8; k++) begin
         step(k < 4, 32'h08070605, 1);
         beat("s2_beat", 8'(k + 1), k == 3 || k == 7);
         if (k == 0) check("s2_busy_ready", {31'd0, ready_o}, 32'd0);
         if (k == 3) check("s2_b4_ready", {31'd0, ready_o}, 32'd1);
      end
      step(0, 32'h0, 1);
      check("s2_idle", {31'd0, valid_o}, 32'd0);
      step(1, 32'hA4A3A2A1, 1);
      step(0, 32'h0, 1); beat("s3_b0", 8'hA1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1, 32'hEEEEEEEE, 0);
         beat("s3_stall", 8'hA2, 1'b0);
         check("s3_stall_ready", {31'd0, ready_o}, 32'd0);
      end
      step(0, 32'h0, 1); beat("s3_b1", 8'hA2, 1'b0);
      step(0, 32'h0, 1); beat("s3_b2", 8'hA3, 1'b0);
      step(0, 32'h0, 1); beat("s3_b3", 8'hA4, 1'b1);
      step(0, 32'h0, 1);
      check("s3_no_capture", {31'd0, valid_o}, 32'd0);
      step(1, 32'h55667788, 1);
      step(0, 32'h0, 1); beat("s4_b0", 8'h88, 1'b0);
      step(0, 32'h0, 1); beat("s4_b1", 8'h77, 1'b0);
      step(0, 32'h0, 1); beat("s4_b2", 8'h66, 1'b0);
      rst_n = 1'b0;
      #1;
      check("s4_rst_valid", {31'd0, valid_o}, 32'd0);
      check("s4_rst_ready", {31'd0, ready_o}, 32'd1);
      check("s4_rst_data", {24'd0, data_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 32'h0, 1);
      check("s4_post_idle", {31'd0, valid_o}, 32'd0);
      step(1, 32'h11223344, 1);
      step(0, 32'h0, 1); beat("s4_n0", 8'h44, 1'b0);
      step(0, 32'h0, 1); beat("s4_n1", 8'h33, 1'b0);
      step(0, 32'h0, 1); beat("s4_n2", 8'h22, 1'b0);
      step(0, 32'h0, 1); beat("s4_n3", 8'h11, 1'b1);
      step(0, 32'h0, 1);
      check("s4_end_idle", {31'd0, valid_o}, 32'd0);
      pops = 0;
      for (int c = 0; c < 1020; c++) begin
         @(posedge clk);
         #1;
         v1_in = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         r1_in = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
         d1_in = 16'($urandom);
         #1;
         check("r1_ready", {31'd0, r1_out}, {31'd0, !v1_out || r1_in});
         if (v1_out && r1_in) begin
            check("r1_nonempty", {31'd0, q.size() != 0}, 32'd1);
            exp1 = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
            check("r1_data", {16'd0, d1_out}, {16'd0, exp1});
            pops++;
         end
         if (v1_in && r1_out) q.push_back(d1_in);
      end
      check("r1_drained", q.size(), 32'd0);
      check("r1_traffic", {31'd0, pops > 100}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
